pipeline_flow_ctrl: RTL and testbench

- Central stall/flush sequencer for Assembled_Superscalar; drives the core's stall and flush inputs, which the core currently takes from the bench.
- Collects back-pressure from the ROB, both reservation stations, the store buffer and an external hold, plus branch-mispredict events from the execute/commit side.
- A Moore FSM produces registered stall, flush and a one-shot PC redirect to fetch, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_flow_ctrl_if.sv | 33 +++
 rtl/pipeline_flow_ctrl.sv | 97 +++++++++
 tb/tb_pipeline_flow_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipeline_flow_ctrl_if.sv
// rtl/pipeline_flow_ctrl_if.sv - back-pressure, mispredict and stall/flush bundle
interface pipeline_flow_ctrl_if #(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 rob_full;
  logic                 rs_al_full;
  logic                 rs_ls_full;
  logic                 sb_full;
  logic                 ext_stall;
  logic                 mispredict;
  logic [PC_WIDTH-1:0]  mispredict_pc;
  logic                 stall;
  logic                 flush;
  logic                 pc_redirect_en;
  logic [PC_WIDTH-1:0]  pc_redirect;
  logic [1:0]           fsm_state;
  logic [CNT_WIDTH-1:0] stall_cycles;

  // flow controller side
  modport master (
    input  rob_full, rs_al_full, rs_ls_full, sb_full, ext_stall,
    input  mispredict, mispredict_pc,
    output stall, flush, pc_redirect_en, pc_redirect, fsm_state, stall_cycles
  );

  // core / pipeline side
  modport slave (
    output rob_full, rs_al_full, rs_ls_full, sb_full, ext_stall,
    output mispredict, mispredict_pc,
    input  stall, flush, pc_redirect_en, pc_redirect, fsm_state, stall_cycles
  );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// rtl/pipeline_flow_ctrl.sv - central stall/flush sequencer with PC redirect
module pipeline_flow_ctrl #(
  parameter int PC_WIDTH     = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int INIT_CYCLES  = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_flow_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t               state;
  logic [3:0]           init_cnt;
  logic [3:0]           flush_cnt;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 redirect_en;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 any_full;

  // Any downstream structure that cannot take a dispatch group holds the front end.
  assign any_full = bus.rob_full | bus.rs_al_full | bus.rs_ls_full |
                    bus.sb_full | bus.ext_stall;

  // Moore FSM: all outputs come from registered state, no input-to-output paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      init_cnt    <= 4'(INIT_CYCLES - 1);
      flush_cnt   <= 4'd0;
      redirect_pc <= '0;
      redirect_en <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      redirect_en <= 1'b0;
      case (state)
        ST_INIT: begin
          // mispredicts are dropped here; the init flush squashes everything
          if (init_cnt == 4'd0) begin
            state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt - 4'd1;
          end
        end
        ST_RUN: begin
          if (bus.mispredict) begin
            redirect_pc <= bus.mispredict_pc;
            redirect_en <= 1'b1;
            flush_cnt   <= 4'(FLUSH_CYCLES - 1);
            state       <= ST_FLUSH;
          end else if (any_full) begin
            state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          if (bus.mispredict) begin
            redirect_pc <= bus.mispredict_pc;
            redirect_en <= 1'b1;
            flush_cnt   <= 4'(FLUSH_CYCLES - 1);
            state       <= ST_FLUSH;
          end else if (!any_full) begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          // always return through RUN so a persisting full re-enters STALL cleanly
          if (flush_cnt == 4'd0) begin
            state <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.stall          = (state != ST_RUN);
  assign bus.flush          = (state == ST_INIT) || (state == ST_FLUSH);
  assign bus.pc_redirect_en = redirect_en;
  assign bus.pc_redirect    = redirect_pc;
  assign bus.fsm_state      = state;
  assign bus.stall_cycles   = stall_cnt;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb/tb_pipeline_flow_ctrl.sv - scoreboard bench for pipeline_flow_ctrl
module tb_pipeline_flow_ctrl;

  typedef struct {
    logic [1:0]  st;
    logic        stall;
    logic        flush;
    logic        en;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  full;      // rob, rs_al, rs_ls, sb, ext
  logic        mp;
  logic [15:0] mpc;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  pipeline_flow_ctrl_if #(.PC_WIDTH(16), .CNT_WIDTH(16)) bus_a ();
  pipeline_flow_ctrl_if #(.PC_WIDTH(16), .CNT_WIDTH(4))  bus_s ();

  assign bus_a.rob_full      = full[4];
  assign bus_a.rs_al_full    = full[3];
  assign bus_a.rs_ls_full    = full[2];
  assign bus_a.sb_full       = full[1];
  assign bus_a.ext_stall     = full[0];
  assign bus_a.mispredict    = mp;
  assign bus_a.mispredict_pc = mpc;
  assign bus_s.rob_full      = full[4];
  assign bus_s.rs_al_full    = full[3];
  assign bus_s.rs_ls_full    = full[2];
  assign bus_s.sb_full       = full[1];
  assign bus_s.ext_stall     = full[0];
  assign bus_s.mispredict    = mp;
  assign bus_s.mispredict_pc = mpc;

  pipeline_flow_ctrl #(.PC_WIDTH(16), .FLUSH_CYCLES(2), .INIT_CYCLES(3), .CNT_WIDTH(16))
    dut (.clk(clk), .reset(reset), .bus(bus_a));
  pipeline_flow_ctrl #(.PC_WIDTH(16), .FLUSH_CYCLES(2), .INIT_CYCLES(3), .CNT_WIDTH(4))
    dut_sat (.clk(clk), .reset(reset), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue what the outputs must be after the edge,
  // then pop and compare against both instances.
  task automatic cyc(input string tag, input logic rst, input logic [4:0] f,
                     input logic m, input logic [15:0] p,
                     input logic [1:0] st, input logic en, input logic [15:0] rpc);
    exp_t e;
    reset = rst; full = f; mp = m; mpc = p;
    e.st = st;
    e.stall = (st != 2'd1);
    e.flush = (st == 2'd0) || (st == 2'd3);
    e.en = en;
    e.pc = rpc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".state"}, 32'(bus_a.fsm_state), 32'(e.st));
    chk({tag, ".stall"}, 32'(bus_a.stall), 32'(e.stall));
    chk({tag, ".flush"}, 32'(bus_a.flush), 32'(e.flush));
    chk({tag, ".redir_en"}, 32'(bus_a.pc_redirect_en), 32'(e.en));
    chk({tag, ".redir_pc"}, 32'(bus_a.pc_redirect), 32'(e.pc));
    chk({tag, ".sat_state"}, 32'(bus_s.fsm_state), 32'(e.st));
  endtask

  initial begin
    reset = 1'b1; full = 5'b0; mp = 1'b0; mpc = 16'h0;
    for (int i = 0; i < 3; i++) cyc("reset", 1, 5'b0, 0, 16'h0, 2'd0, 0, 16'h0);
    chk("reset.cnt", 32'(bus_a.stall_cycles), 32'd0);

    // INIT lasts exactly 3 cycles; mispredict ignored there
    cyc("init0", 0, 5'b0, 1, 16'h1234, 2'd0, 0, 16'h0);
    cyc("init1", 0, 5'b0, 0, 16'h0, 2'd0, 0, 16'h0);
    cyc("init2", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0);
    cyc("run", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0);
    chk("init.cnt", 32'(bus_a.stall_cycles), 32'd0);

    // rs_al_full for 4 cycles
    for (int i = 0; i < 4; i++) cyc("alfull", 0, 5'b01000, 0, 16'h0, 2'd2, 0, 16'h0);
    cyc("alfree", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0);
    chk("alfull.cnt", 32'(bus_a.stall_cycles), 32'd4);
    chk("alfull.sat_cnt", 32'(bus_s.stall_cycles), 32'd4);

    // mispredict, second one during FLUSH dropped
    cyc("mp1", 0, 5'b0, 1, 16'h0040, 2'd3, 1, 16'h0040);
    cyc("mp2", 0, 5'b0, 1, 16'h0080, 2'd3, 0, 16'h0040);
    cyc("mpend", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0040);
    cyc("mprun", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0040);

    // sb_full with simultaneous mispredict: FLUSH, RUN, then STALL
    cyc("sbmp", 0, 5'b00010, 1, 16'h0100, 2'd3, 1, 16'h0100);
    cyc("sbfl", 0, 5'b00010, 0, 16'h0, 2'd3, 0, 16'h0100);
    cyc("sbrun", 0, 5'b00010, 0, 16'h0, 2'd1, 0, 16'h0100);
    cyc("sbst0", 0, 5'b00010, 0, 16'h0, 2'd2, 0, 16'h0100);
    cyc("sbst1", 0, 5'b00010, 0, 16'h0, 2'd2, 0, 16'h0100);
    cyc("sbfree", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0100);
    chk("sb.cnt", 32'(bus_a.stall_cycles), 32'd6);

    // mispredict taken from STALL
    cyc("robst", 0, 5'b10000, 0, 16'h0, 2'd2, 0, 16'h0100);
    cyc("robmp", 0, 5'b10000, 1, 16'h0200, 2'd3, 1, 16'h0200);
    cyc("robfl", 0, 5'b10000, 0, 16'h0, 2'd3, 0, 16'h0200);
    cyc("robrun", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0200);
    chk("rob.cnt", 32'(bus_a.stall_cycles), 32'd7);

    // 20 STALL cycles: wide counter counts on, narrow one holds at 15
    for (int i = 0; i < 20; i++) cyc("ext", 0, 5'b00001, 0, 16'h0, 2'd2, 0, 16'h0200);
    cyc("extfree", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0200);
    chk("sat.wide_cnt", 32'(bus_a.stall_cycles), 32'd27);
    chk("sat.narrow_cnt", 32'(bus_s.stall_cycles), 32'd15);

    // reset mid-FLUSH restarts INIT and clears redirect and counter
    cyc("rfmp", 0, 5'b0, 1, 16'h0300, 2'd3, 1, 16'h0300);
    cyc("rfrst", 1, 5'b0, 0, 16'h0, 2'd0, 0, 16'h0);
    chk("rf.cnt", 32'(bus_a.stall_cycles), 32'd0);
    chk("rf.sat_cnt", 32'(bus_s.stall_cycles), 32'd0);
    cyc("rfi0", 0, 5'b0, 1, 16'h0400, 2'd0, 0, 16'h0);
    cyc("rfi1", 0, 5'b0, 0, 16'h0, 2'd0, 0, 16'h0);
    cyc("rfi2", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0);

    // reset mid-STALL; INIT ignores any_full, then STALL from RUN
    cyc("rsst", 0, 5'b00100, 0, 16'h0, 2'd2, 0, 16'h0);
    cyc("rsrst", 1, 5'b00100, 0, 16'h0, 2'd0, 0, 16'h0);
    cyc("rsi0", 0, 5'b00100, 0, 16'h0, 2'd0, 0, 16'h0);
    cyc("rsi1", 0, 5'b00100, 0, 16'h0, 2'd0, 0, 16'h0);
    cyc("rsi2", 0, 5'b00100, 0, 16'h0, 2'd1, 0, 16'h0);
    cyc("rsst2", 0, 5'b00100, 0, 16'h0, 2'd2, 0, 16'h0);
    cyc("rsfree", 0, 5'b0, 0, 16'h0, 2'd1, 0, 16'h0);
    chk("rs.cnt", 32'(bus_a.stall_cycles), 32'd1);
    chk("q.empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
